// File: rtl/data_memory_responder.sv
// Word-addressed data memory behind a valid/ready request and response handshake.
// Each request is serialized: IDLE -> WAIT (WAIT_CYCLES+1 edges) -> RESP -> IDLE.
module data_memory_responder #(
  parameter int          DEPTH       = 128,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic        write_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        error_r;
  logic [31:0] mem_r [DEPTH];

  logic        accept_s;
  logic        enter_resp_s;
  logic        err_s;
  logic [31:0] index_s;
  logic [AW-1:0] widx_s;

  // Addresses below BASE_ADDR wrap to a huge index and fall out of range.
  assign index_s      = (addr_r - BASE_ADDR) >> 32'd2;
  assign widx_s       = index_s[AW-1:0];
  assign err_s        = (addr_r[1:0] != 2'b00) || (index_s >= 32'(DEPTH));
  assign accept_s     = (state_r == ST_IDLE) && req_valid;
  assign enter_resp_s = (state_r == ST_WAIT) && (cnt_r == 3'd0);

  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign rsp_valid = (state_r == ST_RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_error = error_r;

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s = ST_WAIT;
          cnt_s   = 3'(WAIT_CYCLES);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          state_s = ST_RESP;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // Request latch and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_r <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      error_r <= 1'b0;
    end else if (accept_s) begin
      write_r <= req_write;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      rdata_r <= 32'd0;
      error_r <= 1'b0;
    end else if (enter_resp_s) begin
      if (err_s) begin
        rdata_r <= 32'd0;
        error_r <= 1'b1;
      end else if (write_r) begin
        rdata_r <= 32'd0;
        error_r <= 1'b0;
      end else begin
        rdata_r <= mem_r[widx_s];
        error_r <= 1'b0;
      end
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp_s && write_r && !err_s) begin
      mem_r[widx_s] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed scoreboard bench: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_data_memory_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid_v;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic [1:0]  req_ready_v;
  logic [1:0]  rsp_valid_v;
  logic [1:0]  rsp_error_v;
  logic [1:0]  busy_v;
  logic [31:0] rsp_rdata_v [2];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] sb_q [$];
  logic [31:0] model [2][128];
  time         last_accept;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(128), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_wc2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_v[0]), .rsp_error(rsp_error_v[0]), .busy(busy_v[0])
  );

  data_memory_responder #(.DEPTH(128), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_wc0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_v[1]), .rsp_error(rsp_error_v[1]), .busy(busy_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_is_err(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    return (a[1:0] != 2'b00) || (idx >= 32'd128);
  endfunction

  task automatic check_idle_outputs(input int s, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready_v[s]), 32'd1);
    check({tag, "_busy"},      32'(busy_v[s]),      32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_v[s]), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata_v[s],      32'd0);
    check({tag, "_rsp_error"}, 32'(rsp_error_v[s]), 32'd0);
  endtask

  // One full transaction; called #1 after a rising edge with instance s idle.
  task automatic txn(input int s, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int hold, input int wc);
    logic [32:0] e;
    logic [31:0] idx;
    int n;
    check("req_ready_before_accept", 32'(req_ready_v[s]), 32'd1);
    idx = (a - BASE) >> 2;
    if (addr_is_err(a)) e = {1'b1, 32'd0};
    else if (w) begin
      e = {1'b0, 32'd0};
      model[s][idx[6:0]] = d;
    end else e = {1'b0, model[s][idx[6:0]]};
    sb_q.push_back(e);
    req_write = w; req_addr = a; req_wdata = d;
    req_valid_v[s] = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clk);
    last_accept = $time;
    #1;
    req_valid_v = 2'b00;
    req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (rsp_valid_v[s] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'(wc + 1));
    check("rsp_valid_seen", 32'(rsp_valid_v[s]), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_rdata", rsp_rdata_v[s], e[31:0]);
      check("rsp_error", 32'(rsp_error_v[s]), 32'(e[32]));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(rsp_valid_v[s]), 32'd1);
      check("hold_rsp_rdata", rsp_rdata_v[s], e[31:0]);
      check("hold_rsp_error", 32'(rsp_error_v[s]), 32'(e[32]));
      check("hold_req_ready", 32'(req_ready_v[s]), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_handshake_req_ready", 32'(req_ready_v[s]), 32'd1);
    check("post_handshake_rsp_valid", 32'(rsp_valid_v[s]), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    time prev;
    logic [31:0] d;
    reset = 1'b1; req_valid_v = 2'b00; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    #12;
    check_idle_outputs(0, "reset_wc2");
    check_idle_outputs(1, "reset_wc0");
    @(posedge clk); #1;
    reset = 1'b0;

    // Store then load, then a load under 5 cycles of backpressure.
    txn(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 0, 2);
    txn(0, 1'b0, 32'h1001_0008, 32'h0, 0, 2);
    txn(0, 1'b0, 32'h1001_0008, 32'h0, 5, 2);

    // Error cases must not disturb word 0.
    txn(0, 1'b1, 32'h1001_0000, 32'hA5A5_0000, 0, 2);
    txn(0, 1'b1, 32'h1001_0004, 32'h0BAD_F00D, 0, 2);
    txn(0, 1'b0, 32'h1001_0002, 32'h0, 0, 2);
    txn(0, 1'b0, 32'h1001_0200, 32'h0, 0, 2);
    txn(0, 1'b1, 32'h1000_FFFC, 32'h1234_5678, 0, 2);
    txn(0, 1'b1, 32'h1001_0001, 32'hFFFF_FFFF, 0, 2);
    txn(0, 1'b0, 32'h1001_0000, 32'h0, 0, 2);

    // Reset pulsed during WAIT aborts the store.
    req_write = 1'b1; req_addr = 32'h1001_0004; req_wdata = 32'h55AA_55AA;
    req_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    req_valid_v = 2'b00;
    @(posedge clk); #1;
    check("mid_wait_busy", 32'(busy_v[0]), 32'd1);
    #3 reset = 1'b1;
    #1;
    check_idle_outputs(0, "async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("aborted_no_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
    txn(0, 1'b0, 32'h1001_0004, 32'h0, 0, 2);

    // Zero wait states: fill and read back every word at one transaction per 3 cycles.
    prev = 0;
    for (int i = 0; i < 128; i++) begin
      d = $urandom;
      txn(1, 1'b1, BASE + 32'(i * 4), d, 0, 0);
      if (i > 0) check("b2b_write_period", 32'(last_accept - prev), 32'd30);
      prev = last_accept;
    end
    for (int i = 0; i < 128; i++) begin
      txn(1, 1'b0, BASE + 32'(i * 4), 32'h0, 0, 0);
      if (i > 0) check("b2b_read_period", 32'(last_accept - prev), 32'd30);
      prev = last_accept;
    end
    txn(1, 1'b0, 32'h1001_01FC, 32'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
